// File: rtl/freq_channel_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_channel_scheduler_pkg
// Description : Shared state encoding, range constants and select-width helper
// Revision    : 1.0 - initial release
// ============================================================================
package freq_channel_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PICK    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_START   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_PUBLISH = 3'd5
    } state_t;

    localparam logic RANGE_LONG  = 1'b0;
    localparam logic RANGE_SHORT = 1'b1;

    function automatic int ch_width(input int channels);
        return (channels > 2) ? $clog2(channels) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_channel_scheduler_rr_channel_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_channel_picker
// Description : First set mask bit strictly after last, wrapping at the top
// Revision    : 1.0 - initial release
// ============================================================================
module rr_channel_picker
    import freq_channel_scheduler_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CH_W     = ch_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] mask,
    input  logic [CH_W-1:0]     last,
    output logic [CH_W-1:0]     next_idx,
    output logic                found
);

    logic [CH_W-1:0] idx;

    // Offset 1..CHANNELS so the last-served channel is reconsidered only after all others
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = CH_W'((int'(last) + i) % CHANNELS);
            if (!found && mask[idx]) begin
                found    = 1'b1;
                next_idx = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/freq_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : freq_channel_scheduler
// Description : Round-robin sequencer of a shared measurement engine with
//               per-channel gate autoranging and a valid/ready result port
// Revision    : 1.0 - initial release
// ============================================================================
module freq_channel_scheduler
    import freq_channel_scheduler_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int BITS          = 12,
    parameter int COUNT_BITS    = 7,
    parameter int PERIOD_LONG   = 1200,
    parameter int PERIOD_SHORT  = 120,
    parameter int LOW_THRESH    = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int WATCHDOG      = 4000,
    localparam int CH_W         = ch_width(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CHANNELS-1:0]   chan_mask,
    output logic [CH_W-1:0]       sel,
    output logic                  meas_start,
    output logic [BITS-1:0]       meas_period,
    input  logic                  meas_done,
    input  logic [COUNT_BITS-1:0] meas_count,
    input  logic                  meas_ovf,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CH_W-1:0]       res_chan,
    output logic [COUNT_BITS-1:0] res_count,
    output logic                  res_range,
    output logic                  res_ovf,
    output logic                  res_err
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         sel_q, sel_d;
    logic [CH_W-1:0]         last_q, last_d;
    logic [CHANNELS-1:0]     range_q, range_d;
    logic [BITS-1:0]         wd_q, wd_d;
    logic [SET_W-1:0]        settle_q, settle_d;
    logic                    meas_start_q, meas_start_d;
    logic [BITS-1:0]         meas_period_q, meas_period_d;
    logic                    res_valid_q, res_valid_d;
    logic [CH_W-1:0]         res_chan_q, res_chan_d;
    logic [COUNT_BITS-1:0]   res_count_q, res_count_d;
    logic                    res_range_q, res_range_d;
    logic                    res_ovf_q, res_ovf_d;
    logic                    res_err_q, res_err_d;

    logic [CH_W-1:0]         pick_idx;
    logic                    pick_found;
    logic                    cur_range;

    rr_channel_picker #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_picker (
        .mask     (chan_mask),
        .last     (last_q),
        .next_idx (pick_idx),
        .found    (pick_found)
    );

    assign cur_range = range_q[sel_q];

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_d        = last_q;
        range_d       = range_q;
        wd_d          = wd_q;
        settle_d      = settle_q;
        meas_start_d  = 1'b0;
        meas_period_d = meas_period_q;
        res_valid_d   = res_valid_q;
        res_chan_d    = res_chan_q;
        res_count_d   = res_count_q;
        res_range_d   = res_range_q;
        res_ovf_d     = res_ovf_q;
        res_err_d     = res_err_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && (|chan_mask)) state_d = ST_PICK;
            end
            ST_PICK: begin
                if (pick_found) begin
                    sel_d    = pick_idx;
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // Pulse and period are registered on entry to START
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d       = ST_START;
                    meas_start_d  = 1'b1;
                    meas_period_d = (cur_range == RANGE_SHORT) ? BITS'(PERIOD_SHORT)
                                                               : BITS'(PERIOD_LONG);
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_START: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (meas_done) begin
                    res_chan_d  = sel_q;
                    res_count_d = meas_count;
                    res_ovf_d   = meas_ovf;
                    res_range_d = cur_range;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = ST_PUBLISH;
                    if (cur_range == RANGE_LONG && meas_ovf) begin
                        range_d[sel_q] = RANGE_SHORT;
                    end else if (cur_range == RANGE_SHORT && !meas_ovf &&
                                 meas_count < COUNT_BITS'(LOW_THRESH)) begin
                        range_d[sel_q] = RANGE_LONG;
                    end
                end else if (wd_q == BITS'(WATCHDOG - 1)) begin
                    res_chan_d  = sel_q;
                    res_count_d = '0;
                    res_ovf_d   = 1'b0;
                    res_range_d = cur_range;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = ST_PUBLISH;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_PUBLISH: begin
                if (res_ready) begin
                    last_d      = sel_q;
                    res_valid_d = 1'b0;
                    state_d     = enable ? ST_PICK : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            last_q        <= CH_W'(CHANNELS - 1);
            range_q       <= '0;
            wd_q          <= '0;
            settle_q      <= '0;
            meas_start_q  <= 1'b0;
            meas_period_q <= '0;
            res_valid_q   <= 1'b0;
            res_chan_q    <= '0;
            res_count_q   <= '0;
            res_range_q   <= 1'b0;
            res_ovf_q     <= 1'b0;
            res_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_q        <= last_d;
            range_q       <= range_d;
            wd_q          <= wd_d;
            settle_q      <= settle_d;
            meas_start_q  <= meas_start_d;
            meas_period_q <= meas_period_d;
            res_valid_q   <= res_valid_d;
            res_chan_q    <= res_chan_d;
            res_count_q   <= res_count_d;
            res_range_q   <= res_range_d;
            res_ovf_q     <= res_ovf_d;
            res_err_q     <= res_err_d;
        end
    end

    // Masked so a pulse registered just before reset never leaks into the reset cycle
    assign meas_start  = meas_start_q & ~reset;
    assign sel         = sel_q;
    assign meas_period = meas_period_q;
    assign res_valid   = res_valid_q;
    assign res_chan    = res_chan_q;
    assign res_count   = res_count_q;
    assign res_range   = res_range_q;
    assign res_ovf     = res_ovf_q;
    assign res_err     = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_channel_scheduler
// Description : Scoreboard bench with engine responder and reference model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_channel_scheduler;

    localparam int WATCHDOG = 4000;

    typedef struct packed {
        logic [1:0] chan;
        logic [6:0] cnt;
        logic       rng;
        logic       ovf;
        logic       err;
    } res_t;

    // kind: 0 = answer, 1 = never answer (watchdog result expected), 2 = never answer, no result
    typedef struct packed {
        logic [6:0] cnt;
        logic       ovf;
        logic [1:0] kind;
    } resp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] chan_mask;
    logic [1:0] sel;
    logic       meas_start;
    logic [11:0] meas_period;
    logic       meas_done;
    logic [6:0] meas_count;
    logic       meas_ovf;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_chan;
    logic [6:0] res_count;
    logic       res_range;
    logic       res_ovf;
    logic       res_err;

    freq_channel_scheduler dut (
        .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask),
        .sel(sel), .meas_start(meas_start), .meas_period(meas_period),
        .meas_done(meas_done), .meas_count(meas_count), .meas_ovf(meas_ovf),
        .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
        .res_count(res_count), .res_range(res_range), .res_ovf(res_ovf),
        .res_err(res_err)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    n_starts = 0;
    int    acc_cnt = 0;
    int    accept_cyc = 0;
    int    last_start_cyc = 0;
    int    valid_rise_cyc = 0;
    bit    expect_lat = 0;
    bit    prev_valid = 0;
    bit    hold_ready = 0;
    bit    rnd_ready = 0;
    logic  rng_m [4];
    int    last_m = 3;
    res_t  exp_q [$];
    resp_t force_q [$];
    int    acc_log [$];
    int    period_log [$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic res_t mk_res(input int ch, input logic [6:0] c, input logic r,
                                    input logic o, input logic e);
        res_t x;
        x.chan = 2'(ch); x.cnt = c; x.rng = r; x.ovf = o; x.err = e;
        return x;
    endfunction

    function automatic resp_t mk_resp(input int c, input logic o, input int k);
        resp_t x;
        x.cnt = 7'(c); x.ovf = o; x.kind = 2'(k);
        return x;
    endfunction

    // Smallest participating channel above the last served one, else the smallest overall
    function automatic int next_chan(input logic [3:0] m, input int last);
        int r;
        r = -1;
        for (int c = 3; c >= 0; c--) if (m[c] && c > last) r = c;
        if (r < 0) for (int c = 3; c >= 0; c--) if (m[c]) r = c;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            res_ready = hold_ready ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Engine responder: checks each start against the model and queues the expected result
    initial begin
        meas_done = 1'b0; meas_count = '0; meas_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (meas_start === 1'b1) begin
                int    ch;
                int    d;
                logic  used;
                resp_t r;
                ch   = next_chan(chan_mask, last_m);
                check("start_sel", sel, ch);
                used = (ch >= 0) ? rng_m[ch[1:0]] : 1'b0;
                check("start_period", meas_period, used ? 120 : 1200);
                if (expect_lat) begin
                    check("start_latency", cyc - accept_cyc, 6);
                    expect_lat = 0;
                end
                n_starts++;
                last_start_cyc = cyc;
                period_log.push_back(int'(meas_period));
                if (force_q.size() > 0) begin
                    r = force_q.pop_front();
                end else begin
                    r.kind = 2'd0;
                    r.ovf  = ($urandom_range(0, 3) == 0);
                    r.cnt  = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 15))
                                                         : 7'($urandom_range(0, 127));
                end
                if (r.kind == 2'd0) begin
                    exp_q.push_back(mk_res(ch, r.cnt, used, r.ovf, 1'b0));
                    if (!used && r.ovf) rng_m[ch[1:0]] = 1'b1;
                    else if (used && !r.ovf && r.cnt < 10) rng_m[ch[1:0]] = 1'b0;
                    d = $urandom_range(0, 15);
                    repeat (d + 1) @(posedge clk);
                    #1;
                    meas_done = 1'b1; meas_count = r.cnt; meas_ovf = r.ovf;
                    @(posedge clk);
                    #1;
                    meas_done = 1'b0; meas_count = 7'($urandom); meas_ovf = 1'b0;
                end else if (r.kind == 2'd1) begin
                    exp_q.push_back(mk_res(ch, 7'd0, used, 1'b0, 1'b1));
                end
            end
        end
    end

    // Monitor: every presented result is compared with the head of the scoreboard
    initial forever begin
        @(negedge clk);
        if (reset) begin
            prev_valid = 0;
        end else begin
            if (res_valid && !prev_valid) valid_rise_cyc = cyc;
            prev_valid = res_valid;
            if (res_valid) begin
                res_t got;
                res_t e;
                got = {res_chan, res_count, res_range, res_ovf, res_err};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result chan %0d count %0d err %0d expected no result",
                             res_chan, res_count, res_err);
                end else begin
                    e = exp_q[0];
                    if (got !== e) begin
                        errors++;
                        $display("FAIL result actual chan %0d cnt %0d rng %0d ovf %0d err %0d expected chan %0d cnt %0d rng %0d ovf %0d err %0d",
                                 got.chan, got.cnt, got.rng, got.ovf, got.err,
                                 e.chan, e.cnt, e.rng, e.ovf, e.err);
                    end
                    if (res_ready) begin
                        e = exp_q.pop_front();
                        acc_cnt++;
                        last_m     = int'(e.chan);
                        accept_cyc = cyc;
                        expect_lat = enable;
                        acc_log.push_back(int'(e.chan));
                    end
                end
            end
        end
    end

    task automatic wait_starts(input int target, input int limit);
        int k = 0;
        while (n_starts < target && k < limit) begin @(posedge clk); #1; k++; end
        if (n_starts < target) begin
            checks++; errors++;
            $display("FAIL start_timeout starts %0d expected %0d", n_starts, target);
        end
    endtask

    task automatic wait_accepts(input int target, input int limit);
        int k = 0;
        while (acc_cnt < target && k < limit) begin @(posedge clk); #1; k++; end
        if (acc_cnt < target) begin
            checks++; errors++;
            $display("FAIL accept_timeout accepts %0d expected %0d", acc_cnt, target);
        end
    endtask

    // Run n measurements, dropping enable during the last one so the DUT ends idle
    task automatic run_n(input int n, input int limit);
        int s0;
        int a0;
        s0 = n_starts;
        a0 = acc_cnt;
        enable = 1'b1;
        wait_starts(s0 + n, limit);
        enable = 1'b0;
        wait_accepts(a0 + n, limit);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int s0;
        int a0;
        int k;
        logic [3:0] m;
        for (int c = 0; c < 4; c++) rng_m[c] = 1'b0;
        reset = 1'b1; enable = 1'b1; chan_mask = 4'b0000;

        // Reset and idle
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs",
                  {sel, meas_start, meas_period, res_valid, res_chan, res_count, res_range, res_ovf, res_err},
                  0);
        end
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("idle_no_start", n_starts, 0);
        check("idle_no_valid", res_valid, 0);

        // Round robin over channels 0 and 2
        chan_mask = 4'b0101;
        repeat (4) force_q.push_back(mk_resp(42, 1'b0, 0));
        acc_log.delete(); period_log.delete();
        run_n(4, 400);
        check("rr_count", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) check("rr_chan", acc_log[i], (i % 2) * 2);
        for (int i = 0; i < period_log.size(); i++) check("rr_period", period_log[i], 1200);

        // Autorange on channel 1
        chan_mask = 4'b0010;
        force_q.push_back(mk_resp(127, 1'b1, 0));
        force_q.push_back(mk_resp(5, 1'b0, 0));
        force_q.push_back(mk_resp(42, 1'b0, 0));
        period_log.delete();
        run_n(3, 400);
        check("ar_count", period_log.size(), 3);
        if (period_log.size() == 3) begin
            check("ar_period0", period_log[0], 1200);
            check("ar_period1", period_log[1], 120);
            check("ar_period2", period_log[2], 1200);
        end

        // Backpressure
        chan_mask = 4'b1111;
        s0 = n_starts; a0 = acc_cnt;
        hold_ready = 1; enable = 1'b1;
        wait_starts(s0 + 1, 100);
        k = 0;
        while (!res_valid && k < 100) begin @(posedge clk); #1; k++; end
        repeat (10) begin
            @(negedge clk);
            check("bp_valid_held", res_valid, 1);
            check("bp_no_start", n_starts, s0 + 1);
        end
        @(posedge clk); #1;
        hold_ready = 0;
        wait_starts(s0 + 2, 100);
        check("bp_one_accept", acc_cnt, a0 + 1);
        enable = 1'b0;
        wait_accepts(a0 + 2, 200);
        repeat (3) @(posedge clk);
        #1;

        // Watchdog
        chan_mask = 4'b0001;
        force_q.push_back(mk_resp(0, 1'b0, 1));
        run_n(1, 6000);
        check("wd_latency", valid_rise_cyc - last_start_cyc, WATCHDOG + 1);

        // Randomized masks, responses and ready
        rnd_ready = 1;
        for (int r = 0; r < 6; r++) begin
            m = 4'($urandom_range(1, 15));
            chan_mask = m;
            run_n(5, 1000);
        end
        rnd_ready = 0;

        // Reset during WAIT after channel 1 went SHORT
        chan_mask = 4'b0010;
        force_q.push_back(mk_resp(127, 1'b1, 0));
        run_n(1, 200);
        force_q.push_back(mk_resp(0, 1'b0, 2));
        s0 = n_starts;
        enable = 1'b1;
        wait_starts(s0 + 1, 100);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) rng_m[c] = 1'b0;
        last_m = 3; exp_q.delete(); expect_lat = 0;
        repeat (2) begin
            @(negedge clk);
            check("rst_no_start", meas_start, 0);
            check("rst_no_valid", res_valid, 0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        meas_done = 1'b1; meas_count = 7'd42;
        @(posedge clk); #1;
        meas_done = 1'b0;
        s0 = n_starts;
        k = 0;
        repeat (20) begin @(negedge clk); if (res_valid) k++; end
        check("late_done_ignored", k, 0);
        check("late_done_no_start", n_starts, s0);
        force_q.push_back(mk_resp(42, 1'b0, 0));
        period_log.delete();
        run_n(1, 200);
        check("post_reset_long", (period_log.size() > 0) ? period_log[0] : -1, 1200);

        // Enable dropped mid-measurement leaves the DUT idle afterwards
        s0 = n_starts;
        repeat (20) @(posedge clk);
        #1;
        check("idle_after_disable", n_starts, s0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
